// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
// Optional perf counters are enabled by defining HAZARD_PERF_COUNTERS_EN.
module pipeline_hazard_controller #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ID_rs1,
    input  logic [4:0]      ID_rs2,
    input  logic            ID_rs1_used,
    input  logic            ID_rs2_used,
    input  logic            ID_csr_access,
    input  logic [4:0]      EX_rd,
    input  logic            EX_memory_read,
    input  logic            EX_csr_write_enable,
    input  logic            MEM_csr_write_enable,
    input  logic            EX_redirect,
    input  logic            dmem_busy,
    input  logic            trap_request,
    output logic            pc_stall,
    output logic            IF_ID_stall,
    output logic            IF_ID_flush,
    output logic            ID_EX_stall,
    output logic            ID_EX_flush,
    output logic            EX_MEM_stall,
    output logic            EX_MEM_flush,
`ifdef HAZARD_PERF_COUNTERS_EN
    output logic [XLEN-1:0] stall_cycles,
    output logic [XLEN-1:0] flush_events,
`endif
    output logic            MEM_WB_flush
);

    localparam int unsigned CNT_W = 4;

    if (XLEN < 1 || DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_param
        $error("pipeline_hazard_controller: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_CSR_DRAIN = 2'd1,
        ST_MEM_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d, eff_state;
    logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic               load_use, csr_hazard;

    assign load_use = EX_memory_read && (EX_rd != 5'd0) &&
                      ((ID_rs1_used && (ID_rs1 == EX_rd)) ||
                       (ID_rs2_used && (ID_rs2 == EX_rd)));
    assign csr_hazard = ID_csr_access && (EX_csr_write_enable || MEM_csr_write_enable);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Release from MEM_WAIT re-evaluates hazards as the state it will return to.
    always_comb begin
        pc_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_stall  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_stall = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        eff_state    = state_q;
        if (state_q == ST_MEM_WAIT) begin
            eff_state = (drain_cnt_q != '0) ? ST_CSR_DRAIN : ST_RUN;
        end

        if (reset) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            MEM_WB_flush = 1'b1;
        end else if (trap_request) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            state_d      = ST_RUN;
            drain_cnt_d  = '0;
        end else if (dmem_busy) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_flush = 1'b1;
            state_d      = ST_MEM_WAIT;
        end else if (EX_redirect) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            state_d      = ST_RUN;
            drain_cnt_d  = '0;
        end else if (eff_state == ST_CSR_DRAIN) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_flush  = 1'b1;
            drain_cnt_d  = drain_cnt_q - CNT_W'(1);
            state_d      = (drain_cnt_q == CNT_W'(1)) ? ST_RUN : ST_CSR_DRAIN;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_flush  = 1'b1;
            state_d      = ST_RUN;
        end else if (csr_hazard) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_flush  = 1'b1;
            drain_cnt_d  = CNT_W'(DRAIN_CYCLES - 1);
            state_d      = (DRAIN_CYCLES > 1) ? ST_CSR_DRAIN : ST_RUN;
        end else begin
            state_d      = ST_RUN;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [XLEN-1:0] stall_cycles_q, flush_events_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (pc_stall) begin
                stall_cycles_q <= stall_cycles_q + XLEN'(1);
            end
            if (IF_ID_flush || EX_MEM_flush) begin
                flush_events_q <= flush_events_q + XLEN'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed vectors, expected
// output vectors queued by the driver and checked by an independent monitor.
module tb_pipeline_hazard_controller;

    localparam int unsigned XLEN = 32;

    // {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, EX_MEM_flush, MEM_WB_flush}
    localparam logic [7:0] E_RST  = 8'b0010_1011;
    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_LU   = 8'b1100_1000;
    localparam logic [7:0] E_RED  = 8'b0010_1000;
    localparam logic [7:0] E_TRAP = 8'b0010_1010;
    localparam logic [7:0] E_FRZ  = 8'b1101_0101;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic ID_rs1_used, ID_rs2_used, ID_csr_access, EX_memory_read;
    logic EX_csr_write_enable, MEM_csr_write_enable, EX_redirect, dmem_busy, trap_request;
    logic pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
    logic EX_MEM_stall, EX_MEM_flush, MEM_WB_flush;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [XLEN-1:0] stall_cycles, flush_events;
`endif

    pipeline_hazard_controller #(.XLEN(XLEN), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
        .ID_csr_access(ID_csr_access),
        .EX_rd(EX_rd), .EX_memory_read(EX_memory_read),
        .EX_csr_write_enable(EX_csr_write_enable),
        .MEM_csr_write_enable(MEM_csr_write_enable),
        .EX_redirect(EX_redirect), .dmem_busy(dmem_busy), .trap_request(trap_request),
        .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
        .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_stall(EX_MEM_stall), .EX_MEM_flush(EX_MEM_flush),
`ifdef HAZARD_PERF_COUNTERS_EN
        .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
        .MEM_WB_flush(MEM_WB_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: one expected vector per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_entry_t e;
            logic [7:0] act;
            e   = sb_q.pop_front();
            act = {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
                   EX_MEM_stall, EX_MEM_flush, MEM_WB_flush};
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
            end
        end
    end

    task automatic clear_inputs();
        reset = 1'b0;
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; EX_rd = 5'd0;
        ID_rs1_used = 1'b0; ID_rs2_used = 1'b0; ID_csr_access = 1'b0;
        EX_memory_read = 1'b0; EX_csr_write_enable = 1'b0; MEM_csr_write_enable = 1'b0;
        EX_redirect = 1'b0; dmem_busy = 1'b0; trap_request = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic expect_out(input logic [7:0] exp, input string name);
        sb_entry_t e;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic check_val(input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp, input string name);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;

        // Reset, then idle
        cyc(); reset = 1'b1; expect_out(E_RST, "reset_c1");
        cyc(); reset = 1'b1; expect_out(E_RST, "reset_c2");
        cyc(); expect_out(E_NONE, "idle_after_reset");

        // Load-use on rs1, then bubble
        cyc(); EX_memory_read = 1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_rs1_used = 1;
        expect_out(E_LU, "loaduse_rs1");
        cyc(); ID_rs1 = 5'd5; ID_rs1_used = 1; expect_out(E_NONE, "loaduse_bubble_done");
        // x0 never a hazard
        cyc(); EX_memory_read = 1; EX_rd = 5'd0; ID_rs1 = 5'd0; ID_rs1_used = 1;
        expect_out(E_NONE, "loaduse_x0");

        // CSR drain: 2 cycles of hold
        cyc(); ID_csr_access = 1; EX_csr_write_enable = 1; expect_out(E_LU, "csr_hold_c1");
        cyc(); ID_csr_access = 1; MEM_csr_write_enable = 1; expect_out(E_LU, "csr_hold_c2");
        cyc(); ID_csr_access = 1; expect_out(E_NONE, "csr_released");
`ifdef HAZARD_PERF_COUNTERS_EN
        check_val(stall_cycles, 32'd3, "perf_stall_cycles");
        check_val(flush_events, 32'd0, "perf_flush_events_zero");
`endif

        // More load-use patterns
        cyc(); EX_memory_read = 1; EX_rd = 5'd7; ID_rs2 = 5'd7; ID_rs2_used = 1; ID_rs1 = 5'd3; ID_rs1_used = 1;
        expect_out(E_LU, "loaduse_rs2");
        cyc(); EX_memory_read = 1; EX_rd = 5'd9; ID_rs1 = 5'd9; ID_rs1_used = 0;
        expect_out(E_NONE, "loaduse_rs1_unused");
        cyc(); EX_memory_read = 0; EX_rd = 5'd9; ID_rs1 = 5'd9; ID_rs1_used = 1;
        expect_out(E_NONE, "nonload_match");

        // Load-use with redirect: redirect wins
        cyc(); EX_memory_read = 1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_rs1_used = 1; EX_redirect = 1;
        expect_out(E_RED, "loaduse_plus_redirect");
        cyc(); expect_out(E_NONE, "after_redirect");

        // Redirect aborts CSR drain
        cyc(); ID_csr_access = 1; EX_csr_write_enable = 1; expect_out(E_LU, "csr_abort_c1");
        cyc(); ID_csr_access = 1; EX_redirect = 1; expect_out(E_RED, "csr_abort_redirect");
        cyc(); ID_csr_access = 1; expect_out(E_NONE, "csr_abort_run");

        // New CSR hazard during drain does not restart the count
        cyc(); ID_csr_access = 1; EX_csr_write_enable = 1; expect_out(E_LU, "csr_norestart_c1");
        cyc(); ID_csr_access = 1; EX_csr_write_enable = 1; expect_out(E_LU, "csr_norestart_c2");
        cyc(); ID_csr_access = 1; expect_out(E_NONE, "csr_norestart_done");

        // Freeze 3 cycles with redirect held; redirect fires on release
        for (int i = 0; i < 3; i++) begin
            cyc(); dmem_busy = 1; EX_redirect = 1; expect_out(E_FRZ, "freeze_redirect");
        end
        cyc(); EX_redirect = 1; expect_out(E_RED, "freeze_release_redirect");
        cyc(); expect_out(E_NONE, "freeze_after");

        // Freeze during drain keeps the remaining count
        cyc(); ID_csr_access = 1; EX_csr_write_enable = 1; expect_out(E_LU, "drain_freeze_c1");
        cyc(); ID_csr_access = 1; dmem_busy = 1; expect_out(E_FRZ, "drain_freeze_busy");
        cyc(); ID_csr_access = 1; expect_out(E_LU, "drain_freeze_resume");
        cyc(); ID_csr_access = 1; expect_out(E_NONE, "drain_freeze_done");

        // Load-use re-evaluated on release
        cyc(); dmem_busy = 1; EX_memory_read = 1; EX_rd = 5'd4; ID_rs1 = 5'd4; ID_rs1_used = 1;
        expect_out(E_FRZ, "freeze_loaduse");
        cyc(); EX_memory_read = 1; EX_rd = 5'd4; ID_rs1 = 5'd4; ID_rs1_used = 1;
        expect_out(E_LU, "release_loaduse");
        cyc(); expect_out(E_NONE, "release_loaduse_done");

        // Trap during freeze wins
        cyc(); dmem_busy = 1; expect_out(E_FRZ, "trap_freeze_busy");
        cyc(); dmem_busy = 1; trap_request = 1; EX_redirect = 1; expect_out(E_TRAP, "trap_over_freeze");
        cyc(); expect_out(E_NONE, "trap_after_freeze");

        // Trap aborts drain
        cyc(); ID_csr_access = 1; EX_csr_write_enable = 1; expect_out(E_LU, "trap_drain_c1");
        cyc(); ID_csr_access = 1; trap_request = 1; expect_out(E_TRAP, "trap_in_drain");
        cyc(); ID_csr_access = 1; expect_out(E_NONE, "trap_drain_aborted");

        // Reset aborts drain
        cyc(); ID_csr_access = 1; EX_csr_write_enable = 1; expect_out(E_LU, "rst_drain_c1");
        cyc(); reset = 1; ID_csr_access = 1; expect_out(E_RST, "rst_in_drain");
        cyc(); ID_csr_access = 1; expect_out(E_NONE, "rst_drain_aborted");

`ifdef HAZARD_PERF_COUNTERS_EN
        // Counters cleared by the reset above; one trap counts one flush event
        cyc(); trap_request = 1; expect_out(E_TRAP, "perf_trap");
        cyc(); expect_out(E_NONE, "perf_after_trap");
        check_val(stall_cycles, 32'd0, "perf_stall_after_reset");
        check_val(flush_events, 32'd1, "perf_flush_after_trap");
`endif

        // Drain the scoreboard with a bounded wait
        begin
            int budget;
            budget = 20;
            while (sb_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (sb_q.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
            end
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
